ram_dma_arbiter: RTL and testbench



---
 rtl/ram_dma_arbiter_pkg.sv | 12 +
 rtl/ram_dma_arbiter_sat_counter.sv | 28 ++
 rtl/ram_dma_arbiter.sv | 136 +++++++++++++
 tb/tb_ram_dma_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dma_arbiter_pkg.sv
// Shared definitions for the CPU/DMA system-RAM arbiter.
package arb_pkg;
    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_DMA     = 2'd1,
        ST_RECOVER = 2'd2
    } arb_state_e;

    localparam logic [3:0] RAM_PAGE      = 4'h0;
    localparam int         DEF_MAX_WAIT  = 8;
    localparam int         DEF_BURST_LEN = 4;
endpackage

// File: rtl/ram_dma_arbiter_sat_counter.sv
// Clearable, enabled up-counter that stops at TERM and flags it.
module arb_sat_counter #(
    parameter int             W    = 8,
    parameter logic [W-1:0]   TERM = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !tc_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ram_dma_arbiter.sv
// Shares the single-port system RAM between the CPU (default owner) and one
// DMA requester: free stealing on non-RAM CPU cycles, forced bursts on starvation.
module ram_dma_arbiter
    import arb_pkg::*;
#(
    parameter int AW        = 12,
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   cpu_ab,
    input  logic          cpu_we_n,
    input  logic [7:0]    cpu_do,
    output logic          cpu_rdy,
    output logic [7:0]    cpu_ram_do,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [7:0]    dma_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata
);
    arb_state_e state_q, state_d;
    logic       cpu_sel, cpu_cyc;
    logic       wait_en, wait_clr, wait_tc;
    logic       burst_en, burst_clr, burst_tc;
    logic       dma_rd_q, dma_rd_d;
    logic       cpu_rd_q, cpu_rd_d;
    logic [7:0] held_q, held_d;

    assign cpu_sel = (cpu_ab[15:12] == RAM_PAGE);

    arb_sat_counter #(.W(8), .TERM(8'(MAX_WAIT - 1))) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (wait_clr),
        .en_i  (wait_en),
        .tc_o  (wait_tc)
    );

    arb_sat_counter #(.W(8), .TERM(8'(BURST_LEN - 1))) u_burst_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (burst_clr),
        .en_i  (burst_en),
        .tc_o  (burst_tc)
    );

    always_comb begin
        state_d   = state_q;
        cpu_rdy   = 1'b1;
        dma_gnt   = 1'b0;
        cpu_cyc   = 1'b0;
        ram_addr  = cpu_ab[AW-1:0];
        ram_we    = 1'b0;
        ram_wdata = cpu_do;
        wait_en   = 1'b0;
        wait_clr  = 1'b1;
        burst_en  = 1'b0;
        burst_clr = 1'b1;
        case (state_q)
            ST_CPU: begin
                if (cpu_sel) begin
                    cpu_cyc = 1'b1;
                    ram_we  = ~cpu_we_n;
                end else if (dma_req) begin
                    dma_gnt = 1'b1;
                end
                // A starved request counts up; at terminal count it forces a burst.
                if (dma_req && !dma_gnt) begin
                    if (wait_tc) begin
                        state_d = ST_DMA;
                    end else begin
                        wait_en  = 1'b1;
                        wait_clr = 1'b0;
                    end
                end
            end
            ST_DMA: begin
                cpu_rdy   = 1'b0;
                dma_gnt   = dma_req;
                burst_en  = dma_req;
                burst_clr = 1'b0;
                if (!dma_req || burst_tc) begin
                    state_d   = ST_RECOVER;
                    burst_clr = 1'b1;
                end
            end
            ST_RECOVER: begin
                if (cpu_sel) begin
                    cpu_cyc = 1'b1;
                    ram_we  = ~cpu_we_n;
                end
                state_d = ST_CPU;
            end
            default: state_d = ST_CPU;
        endcase
        if (dma_gnt) begin
            ram_addr  = dma_addr;
            ram_we    = dma_we;
            ram_wdata = dma_wdata;
        end
    end

    // Read data comes back one cycle after the access; the held copy keeps the
    // CPU data bus stable while RDY is low.
    always_comb begin
        dma_rd_d = dma_gnt & ~dma_we;
        cpu_rd_d = cpu_cyc;
        held_d   = cpu_rd_q ? ram_rdata : held_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_CPU;
            dma_rd_q <= 1'b0;
            cpu_rd_q <= 1'b0;
            held_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            dma_rd_q <= dma_rd_d;
            cpu_rd_q <= cpu_rd_d;
            held_q   <= held_d;
        end
    end

    assign dma_rvalid = dma_rd_q;
    assign dma_rdata  = ram_rdata;
    assign cpu_ram_do = cpu_rd_q ? ram_rdata : held_q;
endmodule

// File: tb/tb_ram_dma_arbiter.sv
// Directed bench for ram_dma_arbiter with a cycle model and a RAM array model.
module tb_ram_dma_arbiter;
    localparam int MAX_WAIT  = 8;
    localparam int BURST_LEN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ab;
    logic        cpu_we_n;
    logic [7:0]  cpu_do;
    logic        cpu_rdy;
    logic [7:0]  cpu_ram_do;
    logic        dma_req, dma_we;
    logic [11:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [7:0]  dma_rdata;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_dma_arbiter #(.AW(12), .MAX_WAIT(MAX_WAIT), .BURST_LEN(BURST_LEN)) dut (
        .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_we_n(cpu_we_n), .cpu_do(cpu_do),
        .cpu_rdy(cpu_rdy), .cpu_ram_do(cpu_ram_do), .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // RAM array driven by the DUT port, synchronous read.
    logic [7:0] tmem [4096];
    always @(posedge clk) begin
        ram_rdata <= ram_we ? ram_wdata : tmem[ram_addr];
        if (ram_we) tmem[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: starvation streak, remaining forced beats, recovery slot.
    logic [7:0] mmem [4096];
    int         streak, beats_left;
    bit         recov;
    bit         e_rv, e_cflag;
    logic [7:0] e_rd, e_held;
    bit         e_rdy, e_gnt, e_we, e_cown;
    logic [11:0] e_addr;
    logic [7:0]  e_wd;

    task automatic calc();
        e_rdy = 1; e_gnt = 0; e_cown = 0; e_we = 0;
        e_addr = cpu_ab[11:0]; e_wd = cpu_do;
        if (beats_left > 0) begin
            e_rdy = 0;
            e_gnt = dma_req;
        end else if (cpu_ab[15:12] == 4'h0) begin
            e_cown = 1;
            e_we   = !cpu_we_n;
        end else if (!recov) begin
            e_gnt = dma_req;
        end
        if (e_gnt) begin
            e_addr = dma_addr; e_we = dma_we; e_wd = dma_wdata;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        logic [7:0] rv;
        if (reset) begin
            streak = 0; beats_left = 0; recov = 0;
            e_rv = 0; e_cflag = 0; e_held = 8'h00;
        end else begin
            calc();
            rv = e_we ? e_wd : mmem[e_addr];
            if (e_we) mmem[e_addr] = e_wd;
            if (e_cflag) e_held = e_rd;
            e_rd = rv; e_rv = e_gnt && !dma_we; e_cflag = e_cown;
            if (beats_left > 0) begin
                if (!dma_req) begin beats_left = 0; recov = 1; end
                else begin
                    beats_left--;
                    if (beats_left == 0) recov = 1;
                end
            end else if (recov) begin
                recov = 0;
            end else if (dma_req && !e_gnt) begin
                streak++;
                if (streak == MAX_WAIT) begin streak = 0; beats_left = BURST_LEN; end
            end else begin
                streak = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            calc();
            chk("m_cpu_rdy", cpu_rdy, e_rdy);
            chk("m_dma_gnt", dma_gnt, e_gnt);
            chk("m_ram_we", ram_we, e_we);
            chk("m_ram_addr", ram_addr, e_addr);
            if (e_we) chk("m_ram_wdata", ram_wdata, e_wd);
            chk("m_dma_rvalid", dma_rvalid, e_rv);
            if (e_rv) chk("m_dma_rdata", dma_rdata, e_rd);
            chk("m_cpu_ram_do", cpu_ram_do, e_cflag ? e_rd : e_held);
        end
    end

    task automatic step(input logic [15:0] ab, input logic wen, input logic [7:0] d,
                        input logic rq, input logic dw, input logic [11:0] da, input logic [7:0] dd);
        cpu_ab = ab; cpu_we_n = wen; cpu_do = d;
        dma_req = rq; dma_we = dw; dma_addr = da; dma_wdata = dd;
        #2;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(16'hF000, 1'b1, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00);
    endtask

    initial begin
        logic [13:0] gv, rv;
        int nb, ng, nstall, nwait;
        bit seen, found;
        for (int i = 0; i < 4096; i++) begin tmem[i] = 8'h00; mmem[i] = 8'h00; end
        reset = 1'b1;
        idle();
        chk("rst_cpu_rdy", cpu_rdy, 1);
        chk("rst_dma_gnt", dma_gnt, 0);
        chk("rst_dma_rvalid", dma_rvalid, 0);
        chk("rst_cpu_ram_do", cpu_ram_do, 8'h00);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        tick();

        // CPU-only write then read back
        step(16'h0123, 1'b0, 8'h5A, 1'b0, 1'b0, 12'h000, 8'h00);
        chk("cpu_wr_we", ram_we, 1);
        chk("cpu_wr_addr", ram_addr, 12'h123);
        chk("cpu_wr_gnt", dma_gnt, 0);
        tick();
        step(16'h0123, 1'b1, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00);
        tick();
        chk("cpu_rd_data", cpu_ram_do, 8'h5A);
        chk("cpu_rd_rdy", cpu_rdy, 1);
        step(16'h0010, 1'b0, 8'hC3, 1'b0, 1'b0, 12'h000, 8'h00);
        tick();

        // Steal read and write while CPU is off-page
        step(16'hF000, 1'b1, 8'h00, 1'b1, 1'b0, 12'h010, 8'h00);
        chk("steal_gnt", dma_gnt, 1);
        chk("steal_addr", ram_addr, 12'h010);
        tick();
        idle();
        chk("steal_rvalid", dma_rvalid, 1);
        chk("steal_rdata", dma_rdata, 8'hC3);
        chk("steal_rdy", cpu_rdy, 1);
        tick();
        step(16'hF000, 1'b1, 8'h00, 1'b1, 1'b1, 12'h020, 8'h99);
        chk("steal_wr_we", ram_we, 1);
        tick();
        idle(); tick();

        // Forced burst of DMA writes against a busy CPU
        nb = 0;
        for (int i = 0; i < 14; i++) begin
            step(16'h0300, 1'b1, 8'h00, 1'b1, 1'b1, 12'h200 + 12'(nb), 8'hA0 + 8'(nb));
            gv[i] = dma_gnt; rv[i] = cpu_rdy;
            if (dma_gnt) nb++;
            tick();
        end
        chk("burst_gnt_seq", gv, 14'b00_1111_0000_0000);
        chk("burst_rdy_seq", rv, 14'b11_0000_1111_1111);
        idle(); tick();
        step(16'h0200, 1'b1, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00);
        tick();
        chk("burst_mem0", cpu_ram_do, 8'hA0);
        step(16'h0203, 1'b1, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00);
        tick();
        chk("burst_mem3", cpu_ram_do, 8'hA3);
        idle(); tick();

        // Early burst end after two beats
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(16'h0300, 1'b1, 8'h00, 1'b1, 1'b0, 12'h010, 8'h00);
            if (!cpu_rdy) found = 1;
            tick();
        end
        chk("early_found", found, 1);
        step(16'h0300, 1'b1, 8'h00, 1'b1, 1'b0, 12'h010, 8'h00);
        chk("early_beat2", {dma_gnt, cpu_rdy}, 2'b10);
        tick();
        step(16'h0300, 1'b1, 8'h00, 1'b0, 1'b0, 12'h010, 8'h00);
        chk("early_drop", {dma_gnt, cpu_rdy}, 2'b00);
        tick();
        step(16'h0300, 1'b1, 8'h00, 1'b0, 1'b0, 12'h010, 8'h00);
        chk("early_recover", {dma_gnt, cpu_rdy}, 2'b01);
        tick();
        idle(); tick();

        // CPU read data held across a stall
        step(16'h0040, 1'b0, 8'h77, 1'b0, 1'b0, 12'h000, 8'h00);
        tick();
        seen = 0; nstall = 0;
        for (int i = 0; i < 30; i++) begin
            step(16'h0040, 1'b1, 8'h00, 1'b1, 1'b0, 12'h010, 8'h00);
            if (!cpu_rdy) begin
                seen = 1; nstall++;
                chk("hold_cpu_do", cpu_ram_do, 8'h77);
                if (dma_rvalid) chk("hold_dma_rdata", dma_rdata, 8'hC3);
            end else if (seen) begin
                break;
            end
            tick();
        end
        chk("hold_stalls", nstall, BURST_LEN);
        tick();
        idle(); tick();

        // Reset during the second beat of a forced read burst
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(16'h0300, 1'b1, 8'h00, 1'b1, 1'b0, 12'h030, 8'h00);
            if (!cpu_rdy) found = 1;
            tick();
        end
        chk("rstb_found", found, 1);
        step(16'h0300, 1'b1, 8'h00, 1'b1, 1'b0, 12'h030, 8'h00);
        chk("rstb_rvalid_pre", dma_rvalid, 1);
        reset = 1'b1;
        #1;
        chk("rstb_rdy", cpu_rdy, 1);
        chk("rstb_gnt", dma_gnt, 0);
        chk("rstb_rvalid", dma_rvalid, 0);
        dma_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        nwait = 0; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(16'h0300, 1'b1, 8'h00, 1'b1, 1'b0, 12'h030, 8'h00);
            if (!cpu_rdy) found = 1;
            else if (!dma_gnt) nwait++;
            tick();
        end
        chk("rstb_wait_restart", nwait, MAX_WAIT);
        idle(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
